mrd_fsm_source: RTL

MRD_FSM_SOURCE -- requirements
Module: mrd_fsm_source

---
 rtl/mrd_pkg.sv | 21 ++
 rtl/mrd_bank_mux.sv | 23 ++
 rtl/mrd_fsm_source.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mrd_pkg.sv
// Shared constants and state encoding for the multi-bank frame reader.
package mrd_pkg;

    localparam int NBANK  = 7;
    localparam int RD_LAT = 2;
    localparam int wBANK  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bank 0 drives the MSB of the enable vector.
    function automatic logic [NBANK-1:0] bank_onehot(input logic [wBANK-1:0] bank);
        logic [NBANK-1:0] top;
        top = {1'b1, {(NBANK-1){1'b0}}};
        return top >> bank;
    endfunction

endpackage

// File: rtl/mrd_bank_mux.sv
// Registered 7:1 select of RAM read data; holds its value when no point is valid.
module mrd_bank_mux
    import mrd_pkg::*;
#(
    parameter int wDATA = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [wBANK-1:0] index,
    input  logic [wDATA-1:0] rddata [0:NBANK-1],
    input  logic             valid,
    output logic [wDATA-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (valid && (index < wBANK'(NBANK))) begin
            data <= rddata[index];
        end
    end

endmodule

// File: rtl/mrd_fsm_source.sv
// Reads one frame round-robin out of seven RAM banks and streams it with sop/eop framing.
//   state | meaning
//   IDLE  | waiting for an acceptable start
//   RD    | issuing one bank read per cycle
//   DRAIN | reads issued, waiting for the last point to leave the output register
module mrd_fsm_source
    import mrd_pkg::*;
#(
    parameter int wADDR = 8,
    parameter int wDATA = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [11:0]      frame_len,
    output logic [wADDR-1:0] rdaddr [0:NBANK-1],
    output logic [NBANK-1:0] rden,
    input  logic [wDATA-1:0] rddata [0:NBANK-1],
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [wDATA-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned MAX_LEN = NBANK << wADDR;

    state_t           state, state_nxt;
    logic [11:0]      len_q, pt_cnt;
    logic [wBANK-1:0] bank;
    logic [wADDR-1:0] addr;
    logic             len_ok, accept, last_issue;

    logic [RD_LAT-1:0] dl_valid, dl_sop, dl_eop;
    logic [wBANK-1:0]  dl_bank [RD_LAT];

    assign len_ok     = (frame_len != 12'd0) && (32'(frame_len) <= MAX_LEN);
    assign accept     = (state == IDLE) && start && len_ok;
    assign last_issue = (state == RD) && (pt_cnt == len_q - 12'd1);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD;
            RD:      if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (out_valid && out_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters return to zero after the last issue so rdaddr idles at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            pt_cnt <= '0;
            bank   <= '0;
            addr   <= '0;
        end else if (accept) begin
            len_q  <= frame_len;
            pt_cnt <= '0;
            bank   <= '0;
            addr   <= '0;
        end else if (state == RD) begin
            if (last_issue) begin
                pt_cnt <= '0;
                bank   <= '0;
                addr   <= '0;
            end else begin
                pt_cnt <= pt_cnt + 12'd1;
                if (bank == wBANK'(NBANK - 1)) begin
                    bank <= '0;
                    addr <= addr + 1'b1;
                end else begin
                    bank <= bank + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rden = '0;
        if (state == RD) rden = bank_onehot(bank);
        for (int i = 0; i < NBANK; i++) rdaddr[i] = addr;
    end

    // Delay line matching the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
            dl_sop   <= '0;
            dl_eop   <= '0;
            for (int i = 0; i < RD_LAT; i++) dl_bank[i] <= '0;
        end else begin
            dl_valid   <= {dl_valid[RD_LAT-2:0], (state == RD)};
            dl_sop     <= {dl_sop[RD_LAT-2:0], (state == RD) && (pt_cnt == 12'd0)};
            dl_eop     <= {dl_eop[RD_LAT-2:0], last_issue};
            dl_bank[0] <= bank;
            for (int i = 1; i < RD_LAT; i++) dl_bank[i] <= dl_bank[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= dl_valid[RD_LAT-1];
            out_sop   <= dl_sop[RD_LAT-1];
            out_eop   <= dl_eop[RD_LAT-1];
            done      <= out_valid && out_eop;
            err       <= (state == IDLE) && start && !len_ok;
        end
    end

    mrd_bank_mux #(.wDATA(wDATA)) u_bank_mux (
        .clk    (clk),
        .rst    (rst),
        .index  (dl_bank[RD_LAT-1]),
        .rddata (rddata),
        .valid  (dl_valid[RD_LAT-1]),
        .data   (out_data)
    );

endmodule
